// File: rtl/mul8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier controller built around one shared 4x4 multiplier.
// Optional MUL8_ZERO_SKIP_EN: zero operands bypass the nibble sequence and finish at once.

module multiplier (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] Product
);

    assign Product = A * B;

endmodule

module mul8_seq_ctrl #(
    parameter int unsigned DONE_HOLD = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);

    typedef enum logic [2:0] {
        StIdle,
        StMul0,
        StMul1,
        StMul2,
        StMul3,
        StDone
    } state_e;

    state_e      state;
    logic [7:0]  opa;
    logic [7:0]  opb;
    logic [15:0] acc;
    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic [7:0]  p8;
    logic        accept;
    logic        zero_op;

`ifdef MUL8_ZERO_SKIP_EN
    assign zero_op = (a == 8'h00) || (b == 8'h00);
`else
    assign zero_op = 1'b0;
`endif

    // start is only honoured when no multiplication is in flight
    assign accept = start && ((state == StIdle) || (state == StDone));

    always_comb begin
        mul_a = opa[3:0];
        mul_b = opb[3:0];
        case (state)
            StMul1: mul_b = opb[7:4];
            StMul2: mul_a = opa[7:4];
            StMul3: begin
                mul_a = opa[7:4];
                mul_b = opb[7:4];
            end
            default: ;
        endcase
    end

    multiplier u_multiplier (
        .A       (mul_a),
        .B       (mul_b),
        .Product (p8)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= StIdle;
            opa     <= 8'h00;
            opb     <= 8'h00;
            acc     <= 16'h0000;
            product <= 16'h0000;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (accept) begin
            opa <= a;
            opb <= b;
            acc <= 16'h0000;
            if (zero_op) begin
                state   <= StDone;
                product <= 16'h0000;
                busy    <= 1'b0;
                done    <= 1'b1;
            end else begin
                state <= StMul0;
                busy  <= 1'b1;
                done  <= 1'b0;
            end
        end else begin
            case (state)
                StIdle: ;
                StMul0: begin
                    acc   <= acc + {8'h00, p8};
                    state <= StMul1;
                end
                StMul1: begin
                    acc   <= acc + {4'h0, p8, 4'h0};
                    state <= StMul2;
                end
                StMul2: begin
                    acc   <= acc + {4'h0, p8, 4'h0};
                    state <= StMul3;
                end
                StMul3: begin
                    // final partial goes straight to product so acc never shows through
                    product <= acc + {p8, 8'h00};
                    state   <= StDone;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
                StDone: begin
                    if (DONE_HOLD == 0) begin
                        state <= StIdle;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Scoreboard bench for mul8_seq_ctrl with DONE_HOLD=0; zero-skip latency follows
// MUL8_ZERO_SKIP_EN when the bench is built with the same define.

module tb_mul8_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int          checks;
    int          errors;
    logic [15:0] sb[$];

    mul8_seq_ctrl #(
        .DONE_HOLD (0)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, got, exp, $time);
        end
    endtask

    // Every done pulse must match the oldest outstanding expected product.
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy_done_excl", {15'h0, busy & done}, 16'h0);
            if (done) begin
                if (sb.size() == 0) check("unexpected_done", 16'h1, 16'h0);
                else check("product", product, sb.pop_front());
            end
        end
    end

    function automatic logic [15:0] mul_ref(input logic [7:0] x, input logic [7:0] y);
        return {8'h00, x} * {8'h00, y};
    endfunction

    function automatic bit zero_skip(input logic [7:0] x, input logic [7:0] y);
`ifdef MUL8_ZERO_SKIP_EN
        return (x == 8'h00) || (y == 8'h00);
`else
        return (x == 8'h00) && (y == 8'h00) && 1'b0;
`endif
    endfunction

    // Entered just after a rising edge; returns just after a rising edge.
    task automatic run_op(input logic [7:0] x, input logic [7:0] y);
        start = 1'b1;
        a     = x;
        b     = y;
        sb.push_back(mul_ref(x, y));
        @(posedge clk); #1;
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        if (zero_skip(x, y)) begin
            @(negedge clk);
            check("zs_busy", {15'h0, busy}, 16'h0);
            check("zs_done", {15'h0, done}, 16'h1);
        end else begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                check("busy_high", {15'h0, busy}, 16'h1);
                check("done_low", {15'h0, done}, 16'h0);
            end
            @(negedge clk);
            check("busy_end", {15'h0, busy}, 16'h0);
            check("done_high", {15'h0, done}, 16'h1);
        end
        @(negedge clk);
        check("done_drop", {15'h0, done}, 16'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b1;
        a      = 8'hFF;
        b      = 8'hFF;

        // Reset held with start asserted
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {15'h0, busy}, 16'h0);
        check("rst_done", {15'h0, done}, 16'h0);
        check("rst_product", product, 16'h0000);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy", {15'h0, busy}, 16'h0);
        check("idle_done", {15'h0, done}, 16'h0);

        run_op(8'hFF, 8'hFF);

        // start while busy is ignored; no partial sums leak to product
        start = 1'b1;
        a     = 8'h12;
        b     = 8'h34;
        sb.push_back(16'h03A8);
        @(posedge clk); #1;
        a = 8'hFF;
        b = 8'h01;
        repeat (2) begin
            @(negedge clk);
            check("busy_start_ign", {15'h0, busy}, 16'h1);
            check("prod_hold", product, 16'hFE01);
        end
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("prod_after_ign", product, 16'h03A8);
        check("sb_after_ign", 16'(sb.size()), 16'h0);

        // Back-to-back with start held high
        start = 1'b1;
        a     = 8'h0F;
        b     = 8'h10;
        sb.push_back(16'h00F0);
        @(posedge clk); #1;
        a = 8'h80;
        b = 8'h02;
        repeat (4) @(posedge clk);
        #1;
        check("b2b_done1", {15'h0, done}, 16'h1);
        sb.push_back(16'h0100);
        @(posedge clk); #1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("b2b_busy", {15'h0, busy}, 16'h1);
        end
        @(negedge clk);
        check("b2b_done2", {15'h0, done}, 16'h1);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset sampled on the MUL2 edge discards the operation
        start = 1'b1;
        a     = 8'hAB;
        b     = 8'hCD;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid_rst_busy", {15'h0, busy}, 16'h0);
        check("mid_rst_done", {15'h0, done}, 16'h0);
        check("mid_rst_product", product, 16'h0000);
        repeat (6) @(posedge clk);
        #1;
        check("mid_rst_quiet", product, 16'h0000);

        run_op(8'h03, 8'h05);
        run_op(8'h00, 8'hAB);
        run_op(8'hAB, 8'h00);
        run_op(8'h5A, 8'hA5);
        for (int i = 0; i < 6; i++) begin
            run_op(8'($urandom), 8'($urandom));
        end

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 16'(sb.size()), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
